qsram_access_controller: RTL

- Sequences all accesses to the SDR QSRAM device interface: Enable, Read, Write, Refresh, Address and data direction.
- Shares the device between two requesters (A, B) with round-robin arbitration.
- Issues periodic refresh bursts at a fixed cycle interval.
- Sits between the system-side requesters and the QSRAM pins; the top level ties DataOut/DataOe/DataIn to the inout data bus. Runs on the 100 MHz device clock.

---
 rtl/qsram_access_controller.sv | 122 ++++++++++++
 1 files changed

// File: rtl/qsram_access_controller.sv
// qsram_access_controller: round-robin two-port sequencer for an SDR QSRAM with periodic refresh bursts.
module qsram_access_controller #(
  parameter int ADDR_WIDTH       = 33,
  parameter int DATA_WIDTH       = 9,
  parameter int REFRESH_INTERVAL = 780,
  parameter int REFRESH_CYCLES   = 4,
  parameter int READ_LATENCY     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_a,
  input  logic                  i_req_b,
  input  logic                  i_we_a,
  input  logic                  i_we_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [DATA_WIDTH-1:0] i_wdata_a,
  input  logic [DATA_WIDTH-1:0] i_wdata_b,
  output logic                  o_ack_a,
  output logic                  o_ack_b,
  output logic                  o_rvalid_a,
  output logic                  o_rvalid_b,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_enable,
  output logic                  o_read,
  output logic                  o_write,
  output logic                  o_refresh,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_oe,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  output logic                  o_busy,
  output logic                  o_refresh_overrun
);
  localparam int TW   = $clog2(REFRESH_INTERVAL);
  localparam int CMAX = (REFRESH_CYCLES > READ_LATENCY) ? REFRESH_CYCLES : READ_LATENCY;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_REFRESH, S_WRITE, S_READ, S_READ_WAIT} state_t;

  state_t          r_state, w_next;
  logic [TW-1:0]   r_tmr;
  logic [CW-1:0]   r_cnt;
  logic            r_pend, r_last_b, r_id;
  logic            w_wrap, w_cnt_done, w_enter_ref, w_grant, w_pick_b, w_we, w_rd_done;

  assign w_wrap      = r_tmr == TW'(REFRESH_INTERVAL - 1);
  assign w_cnt_done  = r_cnt == '0;
  assign w_enter_ref = r_state == S_IDLE && r_pend;
  // Pending refresh is registered, so a request arriving with a same-cycle wrap still wins.
  assign w_grant     = r_state == S_IDLE && !r_pend && (i_req_a || i_req_b);
  assign w_pick_b    = i_req_b && (!i_req_a || !r_last_b);
  assign w_we        = w_pick_b ? i_we_b : i_we_a;
  assign w_rd_done   = r_state == S_READ_WAIT && w_cnt_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = r_pend ? S_REFRESH : !w_grant ? S_IDLE : w_we ? S_WRITE : S_READ;
      S_REFRESH:   w_next = w_cnt_done ? S_IDLE : S_REFRESH;
      S_WRITE:     w_next = S_IDLE;
      S_READ:      w_next = S_READ_WAIT;
      S_READ_WAIT: w_next = w_cnt_done ? S_IDLE : S_READ_WAIT;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmr             <= '0;
      r_cnt             <= '0;
      r_pend            <= 1'b0;
      r_last_b          <= 1'b1;
      r_id              <= 1'b0;
      o_ack_a           <= 1'b0;
      o_ack_b           <= 1'b0;
      o_rvalid_a        <= 1'b0;
      o_rvalid_b        <= 1'b0;
      o_rdata           <= '0;
      o_address         <= '0;
      o_enable          <= 1'b0;
      o_read            <= 1'b0;
      o_write           <= 1'b0;
      o_refresh         <= 1'b0;
      o_data_out        <= '0;
      o_data_oe         <= 1'b0;
      o_busy            <= 1'b0;
      o_refresh_overrun <= 1'b0;
    end else begin
      r_tmr             <= w_wrap ? '0 : r_tmr + TW'(1);
      r_pend            <= w_wrap || (r_pend && !w_enter_ref);
      o_refresh_overrun <= o_refresh_overrun || (w_wrap && r_pend);
      // One down-counter serves both the refresh burst and the read wait.
      r_cnt <= w_enter_ref ? CW'(REFRESH_CYCLES - 1) :
               r_state == S_READ ? CW'(READ_LATENCY - 1) :
               w_cnt_done ? r_cnt : r_cnt - CW'(1);
      if (w_grant) begin
        r_id       <= w_pick_b;
        r_last_b   <= w_pick_b;
        o_address  <= w_pick_b ? i_addr_b : i_addr_a;
        o_data_out <= w_pick_b ? i_wdata_b : i_wdata_a;
      end else if (w_enter_ref) begin
        o_address <= '0;
      end
      o_ack_a    <= w_grant && !w_pick_b;
      o_ack_b    <= w_grant && w_pick_b;
      o_enable   <= w_next inside {S_REFRESH, S_WRITE, S_READ};
      o_read     <= w_next == S_READ;
      o_write    <= w_next == S_WRITE;
      o_refresh  <= w_next == S_REFRESH;
      o_data_oe  <= w_next == S_WRITE;
      o_busy     <= w_next != S_IDLE;
      o_rvalid_a <= w_rd_done && !r_id;
      o_rvalid_b <= w_rd_done && r_id;
      if (w_rd_done) o_rdata <= i_data_in;
    end
  end
endmodule
